ppu_reg_if: RTL

//  CPU-facing PPU register interface, $2000-$2007 decoded by sel_in. Holds the

---
 rtl/ppu_pkg.sv | 26 ++
 rtl/ppu_rdbuf.sv | 52 +++++
 rtl/ppu_reg_if.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-register interface.
// Holds the register select codes, the palette constants and the read-buffer states.
package ppu_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_MASK     = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_OAM_ADDR = 3'd3;
    localparam logic [2:0] REG_OAM_DATA = 3'd4;
    localparam logic [2:0] REG_SCROLL   = 3'd5;
    localparam logic [2:0] REG_ADDR     = 3'd6;
    localparam logic [2:0] REG_DATA     = 3'd7;

    localparam logic [5:0]  PAL_PAGE       = 6'h3F;
    localparam logic [13:0] PAL_MIRROR_OFS = 14'h1000;

    typedef enum logic {
        RB_IDLE,
        RB_WAIT
    } rb_state_t;

    function automatic logic in_palette(input logic [14:0] addr);
        return addr[13:8] == PAL_PAGE;
    endfunction

endpackage

// File: rtl/ppu_rdbuf.sv
// PPUDATA read buffer: issues one VRAM refill request per launch and holds it
// until acknowledged. A launch while waiting only re-targets the pending request.
module ppu_rdbuf
    import ppu_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        launch,
    input  logic [13:0] a,
    output logic        req,
    output logic [13:0] rd_a,
    input  logic        ack,
    input  logic [7:0]  d,
    output logic [7:0]  rd_buf
);

    rb_state_t state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= RB_IDLE;
            req    <= 1'b0;
            rd_a   <= '0;
            rd_buf <= '0;
        end else begin
            case (state)
                RB_IDLE: begin
                    if (launch) begin
                        state <= RB_WAIT;
                        req   <= 1'b1;
                        rd_a  <= a;
                    end
                end
                RB_WAIT: begin
                    // An ack arriving with a new launch belongs to the superseded address.
                    if (launch) begin
                        rd_a <= a;
                    end else if (ack) begin
                        state  <= RB_IDLE;
                        req    <= 1'b0;
                        rd_buf <= d;
                    end
                end
                default: begin
                    state <= RB_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ppu_reg_if.sv
// CPU-facing PPU register file ($2000-$2007): CTRL/MASK, loopy scroll latches,
// VRAM address, OAM port, PPUDATA buffering, open-bus latch and vblank/NMI status.
module ppu_reg_if
    import ppu_pkg::*;
#(
    parameter int unsigned INC_HI   = 32,
    parameter int unsigned OB_DECAY = 0,
    parameter int unsigned OB_CW    = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [2:0]  sel_in,
    input  logic        ncs_in,
    input  logic        r_nw_in,
    input  logic [7:0]  cpu_d_in,
    output logic [7:0]  cpu_d_out,
    input  logic        vblank_in,
    input  logic        spr_0_hit_in,
    input  logic        spr_overflow_in,
    output logic        nmi_out,
    output logic [7:0]  ctrl_out,
    output logic [7:0]  mask_out,
    output logic [14:0] t_out,
    output logic [2:0]  fh_out,
    output logic        upd_cntrs_out,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_wr_out,
    output logic        pram_wr_out,
    input  logic [7:0]  pram_d_in,
    output logic        vram_rd_req_out,
    output logic [13:0] vram_rd_a_out,
    input  logic        vram_rd_ack_in,
    input  logic [7:0]  vram_d_in,
    output logic [7:0]  spr_ram_a_out,
    output logic [7:0]  spr_ram_d_out,
    output logic        spr_ram_wr_out,
    input  logic [7:0]  spr_ram_d_in
);

    localparam logic [OB_CW-1:0] DECAY_LIM = OB_CW'(OB_DECAY);
    localparam logic [OB_CW-1:0] DECAY_M1  = OB_CW'(OB_DECAY - 1);

    logic             q_ncs;
    logic             acc, rd, wr;
    logic [7:0]       ctrl, mask, oam_a;
    logic [14:0]      t, v, v_inc;
    logic [2:0]       fh;
    logic             w, upd;
    logic             q_vblank, vblank_flag;
    logic [7:0]       ob;
    logic [OB_CW-1:0] ob_cnt;
    logic [7:0]       rd_data, rd_buf;
    logic             pal_hit, launch;
    logic [13:0]      refill_a;

    // Only the first cycle of a chip-select assertion performs an access.
    assign acc     = q_ncs & ~ncs_in & ~rst_in;
    assign rd      = acc & r_nw_in;
    assign wr      = acc & ~r_nw_in;
    assign pal_hit = in_palette(v);
    assign v_inc   = ctrl[2] ? 15'(INC_HI) : 15'd1;

    always_comb begin
        rd_data = ob;
        case (sel_in)
            REG_STATUS:   rd_data = {vblank_flag, spr_0_hit_in, spr_overflow_in, ob[4:0]};
            REG_OAM_DATA: rd_data = spr_ram_d_in;
            REG_DATA:     rd_data = pal_hit ? pram_d_in : rd_buf;
            default:      rd_data = ob;
        endcase
    end

    assign cpu_d_out = (~ncs_in & r_nw_in & ~rst_in) ? rd_data : 8'h00;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_ncs <= 1'b1;
            ctrl  <= '0;
            mask  <= '0;
            oam_a <= '0;
            t     <= '0;
            v     <= '0;
            fh    <= '0;
            w     <= 1'b0;
            upd   <= 1'b0;
        end else begin
            q_ncs <= ncs_in;
            upd   <= 1'b0;
            if (wr) begin
                case (sel_in)
                    REG_CTRL: begin
                        ctrl      <= cpu_d_in;
                        t[11:10]  <= cpu_d_in[1:0];
                    end
                    REG_MASK:     mask  <= cpu_d_in;
                    REG_OAM_ADDR: oam_a <= cpu_d_in;
                    REG_OAM_DATA: oam_a <= oam_a + 8'd1;
                    REG_SCROLL: begin
                        if (!w) begin
                            fh     <= cpu_d_in[2:0];
                            t[4:0] <= cpu_d_in[7:3];
                        end else begin
                            t[14:12] <= cpu_d_in[2:0];
                            t[9:5]   <= cpu_d_in[7:3];
                        end
                        w <= ~w;
                    end
                    REG_ADDR: begin
                        if (!w) begin
                            t[13:8] <= cpu_d_in[5:0];
                            t[14]   <= 1'b0;
                        end else begin
                            t[7:0] <= cpu_d_in;
                            v      <= {t[14:8], cpu_d_in};
                            upd    <= 1'b1;
                        end
                        w <= ~w;
                    end
                    REG_DATA: v <= v + v_inc;
                    default: ;
                endcase
            end else if (rd) begin
                case (sel_in)
                    REG_STATUS: w <= 1'b0;
                    REG_DATA:   v <= v + v_inc;
                    default: ;
                endcase
            end
        end
    end

    // A rise coinciding with a status read is swallowed, so that read cannot race the NMI.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_vblank    <= 1'b0;
            vblank_flag <= 1'b0;
        end else begin
            q_vblank <= vblank_in;
            if (!vblank_in || (rd && sel_in == REG_STATUS)) begin
                vblank_flag <= 1'b0;
            end else if (vblank_in && !q_vblank) begin
                vblank_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ob     <= '0;
            ob_cnt <= '0;
        end else if (wr) begin
            ob     <= cpu_d_in;
            ob_cnt <= '0;
        end else if (rd) begin
            ob     <= rd_data;
            ob_cnt <= '0;
        end else if (OB_DECAY != 0 && ob_cnt != DECAY_LIM) begin
            ob_cnt <= ob_cnt + OB_CW'(1);
            if (ob_cnt == DECAY_M1) begin
                ob <= '0;
            end
        end
    end

    // Palette space mirrors the refill onto the nametable underneath it.
    assign launch   = rd & (sel_in == REG_DATA);
    assign refill_a = pal_hit ? (v[13:0] - PAL_MIRROR_OFS) : v[13:0];

    ppu_rdbuf u_rdbuf (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .launch (launch),
        .a      (refill_a),
        .req    (vram_rd_req_out),
        .rd_a   (vram_rd_a_out),
        .ack    (vram_rd_ack_in),
        .d      (vram_d_in),
        .rd_buf (rd_buf)
    );

    assign vram_wr_out    = wr & (sel_in == REG_DATA) & ~pal_hit;
    assign pram_wr_out    = wr & (sel_in == REG_DATA) & pal_hit;
    assign vram_d_out     = (wr && sel_in == REG_DATA) ? cpu_d_in : 8'h00;
    assign spr_ram_wr_out = wr & (sel_in == REG_OAM_DATA);
    assign spr_ram_d_out  = spr_ram_wr_out ? cpu_d_in : 8'h00;
    assign spr_ram_a_out  = oam_a;

    assign nmi_out       = ctrl[7] & vblank_flag;
    assign ctrl_out      = ctrl;
    assign mask_out      = mask;
    assign t_out         = t;
    assign fh_out        = fh;
    assign upd_cntrs_out = upd;
    assign vram_a_out    = v[13:0];

endmodule
